// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Purpose:
//   Data-memory stage of the pipeline. Takes the EX/MEM register contents,
//   performs loads, stores, 16-bit push/pop and two-beat 32-bit PC push/pop
//   (CALL/INT and RET/RTI), owns the data memory and the stack pointer, and
//   registers everything into the MEM/WB buffer.
//
// Optional feature (macro STACK_BOUND_CHECK_EN):
//   When defined, a pop issued in IDLE while the stack is empty
//   (SP == SP_RESET) is suppressed and stack_fault pulses for one cycle.
//   When undefined, stack_fault is tied 0 and SP simply wraps.
//
// Ports:
//   clk, reset                 clock (posedge), synchronous active-high reset
//   result                     ALU result (address or write data)
//   read_data1 / read_data2    Rdest / Rsrc values
//   pc_plus_one                return address for 32-bit pushes
//   mem_read, mem_write        load / store
//   mem_push, mem_pop          stack push / pop
//   memory_address_select      00 result, 01 read_data2, 10 stack, 11 = 00
//   memory_write_src_select    00 rd1, 01 rd2, 10 pc_plus_one (2 beats), 11 result
//   pc_choose_memory           with mem_pop: 32-bit PC pop
//   reg_write, wb_sel, reg_write_address, outport_enable,
//   LDM_value, input_port      pass-through to MEM/WB
//   *_out, mem_data_out        registered MEM/WB fields
//   pc_from_memory(_valid)     popped PC and its one-cycle strobe
//   stall                      combinational hold for upstream stages
//   sp_out                     current stack pointer
//   stack_fault                empty-stack pop indication (optional feature)
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int                    ADDR_WIDTH = 11,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET   = 11'h7FF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           result,
    input  logic [15:0]           read_data1,
    input  logic [15:0]           read_data2,
    input  logic [31:0]           pc_plus_one,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_push,
    input  logic                  mem_pop,
    input  logic [1:0]            memory_address_select,
    input  logic [1:0]            memory_write_src_select,
    input  logic                  pc_choose_memory,
    input  logic                  reg_write,
    input  logic [1:0]            wb_sel,
    input  logic [2:0]            reg_write_address,
    input  logic                  outport_enable,
    input  logic [15:0]           LDM_value,
    input  logic [15:0]           input_port,
    output logic [15:0]           mem_data_out,
    output logic [15:0]           result_out,
    output logic [15:0]           LDM_value_out,
    output logic [15:0]           input_port_out,
    output logic                  reg_write_out,
    output logic [1:0]            wb_sel_out,
    output logic [2:0]            reg_write_address_out,
    output logic                  outport_enable_out,
    output logic [31:0]           pc_from_memory,
    output logic                  pc_from_memory_valid,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] sp_out,
    output logic                  stack_fault
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] SP_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_HI = 2'd1,
        POP_LO  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   sp_reg;
    logic [ADDR_WIDTH-1:0]   sp_next;
    logic [15:0]             hi_reg;

    logic [15:0]             mem [0:DEPTH-1];

    logic                    pop_req;
    logic                    pc_push_req;
    logic                    pc_pop_req;
    logic                    pop_fault;
    logic                    do_push;
    logic                    do_pop;
    logic                    write_hi;
    logic                    start_two;
    logic                    bubble;
    logic                    mem_we;
    logic                    read_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [15:0]             mem_wdata;
    logic [15:0]             mem_rdata;

    // Push wins over a simultaneous (illegal) pop.
    assign pop_req     = mem_pop & ~mem_push;
    assign pc_push_req = mem_push & (memory_write_src_select == 2'b10);
    assign pc_pop_req  = pop_req & pc_choose_memory;

`ifdef STACK_BOUND_CHECK_EN
    // Only the first beat of a pop is checked; a legal first beat of a
    // 32-bit pop is allowed to finish even if it empties the stack.
    assign pop_fault = (state_reg == IDLE) & pop_req & (sp_reg == SP_RESET);
`else
    assign pop_fault = 1'b0;
`endif

    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        write_hi  = 1'b0;
        start_two = 1'b0;
        bubble    = 1'b0;
        case (state_reg)
            PUSH_HI: begin
                do_push  = 1'b1;
                write_hi = 1'b1;
            end
            POP_LO: begin
                do_pop = 1'b1;
            end
            default: begin
                do_push   = mem_push;
                do_pop    = pop_req & ~pop_fault;
                start_two = pc_push_req | (pc_pop_req & ~pop_fault);
                bubble    = start_two | pop_fault;
            end
        endcase
    end

    // Stack accesses override the address select: push addresses SP
    // (post-decrement), pop addresses SP+1 (pre-increment).
    always_comb begin
        mem_addr = result[ADDR_WIDTH-1:0];
        if (do_push) begin
            mem_addr = sp_reg;
        end else if (do_pop) begin
            mem_addr = sp_reg + SP_ONE;
        end else begin
            case (memory_address_select)
                2'b01:   mem_addr = read_data2[ADDR_WIDTH-1:0];
                2'b10:   mem_addr = sp_reg;
                default: mem_addr = result[ADDR_WIDTH-1:0];
            endcase
        end
    end

    always_comb begin
        mem_wdata = read_data1;
        if (write_hi) begin
            mem_wdata = pc_plus_one[31:16];
        end else begin
            case (memory_write_src_select)
                2'b01:   mem_wdata = read_data2;
                2'b10:   mem_wdata = pc_plus_one[15:0];
                2'b11:   mem_wdata = result;
                default: mem_wdata = read_data1;
            endcase
        end
    end

    always_comb begin
        sp_next = sp_reg;
        if (do_push) begin
            sp_next = sp_reg - SP_ONE;
        end else if (do_pop) begin
            sp_next = sp_reg + SP_ONE;
        end
    end

    // Reset suppresses writes so an aborted CALL leaves only its first beat.
    assign mem_we    = (do_push | mem_write) & ~reset;
    assign read_en   = mem_read | do_pop;
    assign mem_rdata = mem[mem_addr];

    assign stall  = start_two & ~reset;
    assign sp_out = sp_reg;

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg             <= IDLE;
            sp_reg                <= SP_RESET;
            hi_reg                <= '0;
            mem_data_out          <= '0;
            result_out            <= '0;
            LDM_value_out         <= '0;
            input_port_out        <= '0;
            reg_write_out         <= 1'b0;
            wb_sel_out            <= '0;
            reg_write_address_out <= '0;
            outport_enable_out    <= 1'b0;
            pc_from_memory        <= '0;
            pc_from_memory_valid  <= 1'b0;
        end else begin
            sp_reg                <= sp_next;
            result_out            <= result;
            LDM_value_out         <= LDM_value;
            input_port_out        <= input_port;
            wb_sel_out            <= wb_sel;
            reg_write_address_out <= reg_write_address;
            reg_write_out         <= reg_write & ~bubble;
            outport_enable_out    <= outport_enable & ~bubble;
            pc_from_memory_valid  <= 1'b0;
            if (read_en) begin
                mem_data_out <= mem_rdata;
            end
            case (state_reg)
                PUSH_HI: begin
                    state_reg <= IDLE;
                end
                POP_LO: begin
                    pc_from_memory       <= {hi_reg, mem_rdata};
                    pc_from_memory_valid <= 1'b1;
                    state_reg            <= IDLE;
                end
                default: begin
                    if (pc_push_req) begin
                        state_reg <= PUSH_HI;
                    end else if (pc_pop_req && !pop_fault) begin
                        hi_reg    <= mem_rdata;
                        state_reg <= POP_LO;
                    end
                end
            endcase
        end
    end

`ifdef STACK_BOUND_CHECK_EN
    logic stack_fault_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stack_fault_reg <= 1'b0;
        end else begin
            stack_fault_reg <= pop_fault;
        end
    end

    assign stack_fault = stack_fault_reg;
`else
    assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result, read_data1, read_data2;
    logic [31:0] pc_plus_one;
    logic        mem_read, mem_write, mem_push, mem_pop;
    logic [1:0]  memory_address_select, memory_write_src_select;
    logic        pc_choose_memory;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  reg_write_address;
    logic        outport_enable;
    logic [15:0] LDM_value, input_port;
    logic [15:0] mem_data_out, result_out, LDM_value_out, input_port_out;
    logic        reg_write_out;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out;
    logic        outport_enable_out;
    logic [31:0] pc_from_memory;
    logic        pc_from_memory_valid;
    logic        stall;
    logic [10:0] sp_out;
    logic        stack_fault;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset), .result(result), .read_data1(read_data1),
        .read_data2(read_data2), .pc_plus_one(pc_plus_one), .mem_read(mem_read),
        .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .pc_choose_memory(pc_choose_memory), .reg_write(reg_write), .wb_sel(wb_sel),
        .reg_write_address(reg_write_address), .outport_enable(outport_enable),
        .LDM_value(LDM_value), .input_port(input_port), .mem_data_out(mem_data_out),
        .result_out(result_out), .LDM_value_out(LDM_value_out),
        .input_port_out(input_port_out), .reg_write_out(reg_write_out),
        .wb_sel_out(wb_sel_out), .reg_write_address_out(reg_write_address_out),
        .outport_enable_out(outport_enable_out), .pc_from_memory(pc_from_memory),
        .pc_from_memory_valid(pc_from_memory_valid), .stall(stall), .sp_out(sp_out),
        .stack_fault(stack_fault)
    );

    typedef struct {
        string       name;
        logic [4:0]  ctl;      // {rd, wr, push, pop, pc_choose}
        logic [1:0]  asel;
        logic [1:0]  wsel;
        logic [15:0] res;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [31:0] pc1;
        logic        chk_data;
        logic [15:0] exp_data;
        logic [10:0] exp_sp;
        logic        exp_stall;
        logic        exp_rw;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [15:0] ldm;
        logic [15:0] inp;
        logic [1:0]  wb;
        logic [2:0]  rwa;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input string name, input logic [4:0] ctl,
                                input logic [1:0] asel, input logic [1:0] wsel,
                                input logic [15:0] res, input logic [15:0] rd1,
                                input logic [15:0] rd2, input logic [31:0] pc1,
                                input logic chk, input logic [15:0] ed,
                                input logic [10:0] esp, input logic est,
                                input logic erw, input logic ev, input logic [31:0] epc);
        vec_t v;
        v.name = name; v.ctl = ctl; v.asel = asel; v.wsel = wsel;
        v.res = res; v.rd1 = rd1; v.rd2 = rd2; v.pc1 = pc1;
        v.chk_data = chk; v.exp_data = ed; v.exp_sp = esp; v.exp_stall = est;
        v.exp_rw = erw; v.exp_valid = ev; v.exp_pc = epc; v.exp_fault = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_idle();
        result = '0; read_data1 = '0; read_data2 = '0; pc_plus_one = '0;
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        memory_address_select = '0; memory_write_src_select = '0;
        pc_choose_memory = 0; reg_write = 0; wb_sel = '0; reg_write_address = '0;
        outport_enable = 0; LDM_value = '0; input_port = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        exp_t e;
        {mem_read, mem_write, mem_push, mem_pop, pc_choose_memory} = v.ctl;
        memory_address_select = v.asel; memory_write_src_select = v.wsel;
        result = v.res; read_data1 = v.rd1; read_data2 = v.rd2; pc_plus_one = v.pc1;
        reg_write = 1'b1; outport_enable = 1'b1;
        LDM_value = 16'($urandom); input_port = 16'($urandom);
        wb_sel = 2'($urandom_range(0, 3)); reg_write_address = 3'($urandom_range(0, 7));
        e.v = v; e.ldm = LDM_value; e.inp = input_port; e.wb = wb_sel;
        e.rwa = reg_write_address;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive_vec(v);
        #1 chk({v.name, ":stall"}, 32'(stall), 32'(v.exp_stall));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.v.name, ":sp"}, 32'(sp_out), 32'(e.v.exp_sp));
        chk({e.v.name, ":reg_write_out"}, 32'(reg_write_out), 32'(e.v.exp_rw));
        chk({e.v.name, ":outport_en_out"}, 32'(outport_enable_out), 32'(e.v.exp_rw));
        chk({e.v.name, ":pc_valid"}, 32'(pc_from_memory_valid), 32'(e.v.exp_valid));
        chk({e.v.name, ":pc"}, pc_from_memory, e.v.exp_pc);
        chk({e.v.name, ":fault"}, 32'(stack_fault), 32'(e.v.exp_fault));
        chk({e.v.name, ":result_out"}, 32'(result_out), 32'(e.v.res));
        chk({e.v.name, ":ldm_out"}, 32'(LDM_value_out), 32'(e.ldm));
        chk({e.v.name, ":inport_out"}, 32'(input_port_out), 32'(e.inp));
        chk({e.v.name, ":wb_sel_out"}, 32'(wb_sel_out), 32'(e.wb));
        chk({e.v.name, ":rwa_out"}, 32'(reg_write_address_out), 32'(e.rwa));
        if (e.v.chk_data) begin
            chk({e.v.name, ":data"}, 32'(mem_data_out), 32'(e.v.exp_data));
        end
        $display("vec %-10s sp=%h data=%h pc=%h valid=%0d", e.v.name, sp_out,
                 mem_data_out, pc_from_memory, pc_from_memory_valid);
    endtask

    initial begin
        vec_t v;
        localparam logic [31:0] PC1 = 32'h0001_0020;

        tbl.push_back(mk("store",    5'b01000, 2'd0, 2'd0, 16'h0010, 16'hBEEF, 16'h0000, 0,   0, 0,        11'h7FF, 0, 1, 0, 0));
        tbl.push_back(mk("load",     5'b10000, 2'd0, 2'd0, 16'h0010, 16'h0000, 16'h0000, 0,   1, 16'hBEEF, 11'h7FF, 0, 1, 0, 0));
        tbl.push_back(mk("push16",   5'b00100, 2'd2, 2'd0, 16'h0000, 16'h1234, 16'h0000, 0,   0, 0,        11'h7FE, 0, 1, 0, 0));
        tbl.push_back(mk("pop16",    5'b00010, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0,   1, 16'h1234, 11'h7FF, 0, 1, 0, 0));
        tbl.push_back(mk("call_b1",  5'b00100, 2'd2, 2'd2, 16'h0000, 16'h0000, 16'h0000, PC1, 0, 0,        11'h7FE, 1, 0, 0, 0));
        tbl.push_back(mk("call_b2",  5'b00100, 2'd2, 2'd2, 16'h0000, 16'h0000, 16'h0000, PC1, 0, 0,        11'h7FD, 0, 1, 0, 0));
        tbl.push_back(mk("ld_7ff",   5'b10000, 2'd1, 2'd0, 16'h0000, 16'h0000, 16'h07FF, 0,   1, 16'h0020, 11'h7FD, 0, 1, 0, 0));
        tbl.push_back(mk("ld_7fe",   5'b10000, 2'd0, 2'd0, 16'h07FE, 16'h0000, 16'h0000, 0,   1, 16'h0001, 11'h7FD, 0, 1, 0, 0));
        tbl.push_back(mk("ret_b1",   5'b00011, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0,   0, 0,        11'h7FE, 1, 0, 0, 0));
        tbl.push_back(mk("ret_b2",   5'b00011, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0,   0, 0,        11'h7FF, 0, 1, 1, PC1));
        tbl.push_back(mk("nop",      5'b00000, 2'd0, 2'd0, 16'h0042, 16'h0000, 16'h0000, 0,   0, 0,        11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("push_pop", 5'b00110, 2'd2, 2'd0, 16'h0000, 16'h5555, 16'h0000, 0,   0, 0,        11'h7FE, 0, 1, 0, PC1));
        tbl.push_back(mk("pop16b",   5'b00010, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0,   1, 16'h5555, 11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("rw_same",  5'b11000, 2'd0, 2'd0, 16'h0010, 16'h1111, 16'h0000, 0,   1, 16'hBEEF, 11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("ld_10",    5'b10000, 2'd0, 2'd0, 16'h0010, 16'h0000, 16'h0000, 0,   1, 16'h1111, 11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("st_res",   5'b01000, 2'd1, 2'd3, 16'h0ABC, 16'h0000, 16'h0020, 0,   0, 0,        11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("ld_20",    5'b10000, 2'd1, 2'd0, 16'h0000, 16'h0000, 16'h0020, 0,   1, 16'h0ABC, 11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("st_rd2",   5'b01000, 2'd0, 2'd1, 16'h0030, 16'h0000, 16'h7777, 0,   0, 0,        11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("ld_rsv",   5'b10000, 2'd3, 2'd0, 16'h0030, 16'h0000, 16'h0000, 0,   1, 16'h7777, 11'h7FF, 0, 1, 0, PC1));
        tbl.push_back(mk("st_aaaa",  5'b01000, 2'd0, 2'd0, 16'h07FE, 16'hAAAA, 16'h0000, 0,   0, 0,        11'h7FF, 0, 1, 0, PC1));

        // Reset: two cycles, then every registered output must be clear.
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:stall", 32'(stall), 0);
        reset = 1'b0;
        chk("rst:sp", 32'(sp_out), 32'h7FF);
        chk("rst:data", 32'(mem_data_out), 0);
        chk("rst:result_out", 32'(result_out), 0);
        chk("rst:reg_write_out", 32'(reg_write_out), 0);
        chk("rst:pc", pc_from_memory, 0);
        chk("rst:pc_valid", 32'(pc_from_memory_valid), 0);
        chk("rst:fault", 32'(stack_fault), 0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset during PUSH_HI: SP back to top, second beat never written.
        run_vec(mk("call2_b1", 5'b00100, 2'd2, 2'd2, 16'h0000, 16'h0000, 16'h0000, 32'h0003_0044,
                   0, 0, 11'h7FE, 1, 0, 0, PC1));
        @(negedge clk);
        reset = 1'b1;
        #1 chk("abort:stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("abort:sp", 32'(sp_out), 32'h7FF);
        chk("abort:pc_valid", 32'(pc_from_memory_valid), 0);
        chk("abort:reg_write_out", 32'(reg_write_out), 0);
        chk("abort:pc", pc_from_memory, 0);
        $display("vec %-10s sp=%h", "abort", sp_out);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        run_vec(mk("ab_ld_7fe", 5'b10000, 2'd0, 2'd0, 16'h07FE, 0, 0, 0, 1, 16'hAAAA, 11'h7FF, 0, 1, 0, 0));
        run_vec(mk("ab_ld_7ff", 5'b10000, 2'd0, 2'd0, 16'h07FF, 0, 0, 0, 1, 16'h0044, 11'h7FF, 0, 1, 0, 0));

        // Pop on an empty stack.
`ifdef STACK_BOUND_CHECK_EN
        v = mk("empty_pop", 5'b00010, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 11'h7FF, 0, 0, 0, 0);
        v.exp_fault = 1'b1;
        run_vec(v);
        run_vec(mk("after_flt", 5'b00000, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 11'h7FF, 0, 1, 0, 0));
        v = mk("empty_ret", 5'b00011, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 11'h7FF, 0, 0, 0, 0);
        v.exp_fault = 1'b1;
        run_vec(v);
`else
        v = mk("empty_pop", 5'b00010, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 11'h000, 0, 1, 0, 0);
        run_vec(v);
        run_vec(mk("wrap_push", 5'b00100, 2'd2, 2'd0, 0, 16'h9999, 0, 0, 0, 0, 11'h7FF, 0, 1, 0, 0));
`endif

        @(negedge clk);
        drive_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
